// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous memory between the fetch (I) and data (D) ports.
// D has priority; a starvation counter guarantees that a waiting fetch eventually wins.
module mem_port_arbiter #(
  parameter int AW         = 12,
  parameter int DW         = 32,
  parameter int LAT        = 1,
  parameter int MAX_STARVE = 4
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              I_REQ,
  input  logic [AW-1:0]     I_ADDR,
  output logic              I_GNT,
  output logic              I_RVALID,
  output logic [DW-1:0]     I_RDATA,
  input  logic              D_REQ,
  input  logic              D_WE,
  input  logic [AW-1:0]     D_ADDR,
  input  logic [DW/8-1:0]   D_BE,
  input  logic [DW-1:0]     D_WDATA,
  output logic              D_GNT,
  output logic              D_RVALID,
  output logic [DW-1:0]     D_RDATA,
  output logic              MEM_CSN,
  output logic              MEM_WEN,
  output logic [AW-1:0]     MEM_ADDR,
  output logic [DW/8-1:0]   MEM_BE,
  output logic [DW-1:0]     MEM_WDATA,
  input  logic [DW-1:0]     MEM_RDATA,
  output logic [31:0]       NUM_I_GNT,
  output logic [31:0]       NUM_D_GNT
);

  localparam int SW = $clog2(MAX_STARVE + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t        state;
  state_t        state_nxt;
  logic          owner_d;
  logic          we_q;
  logic [2:0]    lat_cnt;
  logic [SW-1:0] starve;
  logic          window;
  logic          d_win;
  logic          i_win;
  logic          last_wait;

  always_comb begin
    window    = RSTn && ((state == IDLE) || (state == RESP));
    d_win     = window && D_REQ && !(I_REQ && (starve == SW'(MAX_STARVE)));
    i_win     = window && I_REQ && !d_win;
    last_wait = (state == WAIT) && (lat_cnt == 3'(LAT));
    state_nxt = state;
    case (state)
      IDLE, RESP: state_nxt = (d_win || i_win) ? ACCESS : IDLE;
      ACCESS:     state_nxt = (owner_d && we_q) ? RESP : WAIT;
      WAIT:       state_nxt = last_wait ? RESP : WAIT;
      default:    state_nxt = IDLE;
    endcase
  end

  // Strobes are gated by RSTn so a reset cuts an in-flight access in the same cycle.
  assign I_GNT    = i_win;
  assign D_GNT    = d_win;
  assign MEM_CSN  = !(RSTn && (state == ACCESS));
  assign MEM_WEN  = !(RSTn && (state == ACCESS) && owner_d && we_q);
  assign I_RVALID = RSTn && (state == RESP) && !owner_d;
  assign D_RVALID = RSTn && (state == RESP) && owner_d;

  always_ff @(posedge CLK) begin
    if (!RSTn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      owner_d   <= 1'b0;
      we_q      <= 1'b0;
      lat_cnt   <= '0;
      starve    <= '0;
      MEM_ADDR  <= '0;
      MEM_BE    <= '0;
      MEM_WDATA <= '0;
      I_RDATA   <= '0;
      D_RDATA   <= '0;
      NUM_I_GNT <= '0;
      NUM_D_GNT <= '0;
    end else begin
      if (d_win) begin
        owner_d   <= 1'b1;
        we_q      <= D_WE;
        MEM_ADDR  <= D_ADDR;
        MEM_BE    <= D_BE;
        MEM_WDATA <= D_WDATA;
        NUM_D_GNT <= NUM_D_GNT + 32'd1;
        if (I_REQ && (starve != SW'(MAX_STARVE))) starve <= starve + SW'(1);
      end else if (i_win) begin
        owner_d   <= 1'b0;
        we_q      <= 1'b0;
        MEM_ADDR  <= I_ADDR;
        MEM_BE    <= '1;
        NUM_I_GNT <= NUM_I_GNT + 32'd1;
        starve    <= '0;
      end
      if (state == ACCESS)    lat_cnt <= 3'd1;
      else if (state == WAIT) lat_cnt <= lat_cnt + 3'd1;
      // Read data is sampled at the end of the last latency cycle into the owner's register.
      if (last_wait) begin
        if (owner_d) D_RDATA <= MEM_RDATA;
        else         I_RDATA <= MEM_RDATA;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one LAT=1 instance and one LAT=3 instance share stimulus.
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        I_REQ, D_REQ, D_WE;
  logic [11:0] I_ADDR, D_ADDR;
  logic [3:0]  D_BE;
  logic [31:0] D_WDATA, MEM_RDATA;

  logic        i_gnt_a, i_rvalid_a, d_gnt_a, d_rvalid_a, csn_a, wen_a;
  logic [31:0] i_rdata_a, d_rdata_a, wdata_a, num_i_a, num_d_a;
  logic [11:0] addr_a;
  logic [3:0]  be_a;

  logic        i_gnt_b, i_rvalid_b, d_gnt_b, d_rvalid_b, csn_b, wen_b;
  logic [31:0] i_rdata_b, d_rdata_b, wdata_b, num_i_b, num_d_b;
  logic [11:0] addr_b;
  logic [3:0]  be_b;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.AW(12), .DW(32), .LAT(1), .MAX_STARVE(4)) dut_a (
    .CLK(CLK), .RSTn(RSTn),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(i_gnt_a), .I_RVALID(i_rvalid_a), .I_RDATA(i_rdata_a),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_BE(D_BE), .D_WDATA(D_WDATA),
    .D_GNT(d_gnt_a), .D_RVALID(d_rvalid_a), .D_RDATA(d_rdata_a),
    .MEM_CSN(csn_a), .MEM_WEN(wen_a), .MEM_ADDR(addr_a), .MEM_BE(be_a), .MEM_WDATA(wdata_a),
    .MEM_RDATA(MEM_RDATA), .NUM_I_GNT(num_i_a), .NUM_D_GNT(num_d_a)
  );

  mem_port_arbiter #(.AW(12), .DW(32), .LAT(3), .MAX_STARVE(4)) dut_b (
    .CLK(CLK), .RSTn(RSTn),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(i_gnt_b), .I_RVALID(i_rvalid_b), .I_RDATA(i_rdata_b),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_BE(D_BE), .D_WDATA(D_WDATA),
    .D_GNT(d_gnt_b), .D_RVALID(d_rvalid_b), .D_RDATA(d_rdata_b),
    .MEM_CSN(csn_b), .MEM_WEN(wen_b), .MEM_ADDR(addr_b), .MEM_BE(be_b), .MEM_WDATA(wdata_b),
    .MEM_RDATA(MEM_RDATA), .NUM_I_GNT(num_i_b), .NUM_D_GNT(num_d_b)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RSTn = 1'b0; I_REQ = 1'b0; D_REQ = 1'b0; D_WE = 1'b0;
    I_ADDR = '0; D_ADDR = '0; D_BE = '0; D_WDATA = '0; MEM_RDATA = '0;
    repeat (3) next_cycle();

    // reset state, grants forced low while RSTn is low
    I_REQ = 1'b1; D_REQ = 1'b1; #1;
    check_output("rst_i_gnt", i_gnt_a, 0);
    check_output("rst_d_gnt", d_gnt_a, 0);
    check_output("rst_csn", csn_a, 1);
    check_output("rst_wen", wen_a, 1);
    check_output("rst_addr", addr_a, 0);
    check_output("rst_be", be_a, 0);
    check_output("rst_wdata", wdata_a, 0);
    check_output("rst_i_rvalid", i_rvalid_a, 0);
    check_output("rst_d_rvalid", d_rvalid_a, 0);
    check_output("rst_i_rdata", i_rdata_a, 0);
    check_output("rst_d_rdata", d_rdata_a, 0);
    check_output("rst_num_i", num_i_a, 0);
    check_output("rst_num_d", num_d_a, 0);
    I_REQ = 1'b0; D_REQ = 1'b0;

    // LAT=1 fetch
    next_cycle();
    RSTn = 1'b1; I_REQ = 1'b1; I_ADDR = 12'h010; #1;
    check_output("f_i_gnt", i_gnt_a, 1);
    check_output("f_d_gnt", d_gnt_a, 0);
    next_cycle();
    I_REQ = 1'b0; #1;
    check_output("f_acc_csn", csn_a, 0);
    check_output("f_acc_wen", wen_a, 1);
    check_output("f_acc_addr", addr_a, 32'h010);
    check_output("f_acc_be", be_a, 32'hF);
    check_output("f_acc_i_gnt", i_gnt_a, 0);
    next_cycle();
    MEM_RDATA = 32'hDEADBEEF; #1;
    check_output("f_wait_csn", csn_a, 1);
    check_output("f_wait_rvalid", i_rvalid_a, 0);
    next_cycle();
    MEM_RDATA = 32'h0; #1;
    check_output("f_resp_rvalid", i_rvalid_a, 1);
    check_output("f_resp_rdata", i_rdata_a, 32'hDEADBEEF);
    check_output("f_num_i", num_i_a, 1);
    check_output("f_resp_d_rvalid", d_rvalid_a, 0);
    next_cycle();
    check_output("f_post_rvalid", i_rvalid_a, 0);
    check_output("f_hold_rdata", i_rdata_a, 32'hDEADBEEF);

    // D store
    D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 12'h020; D_BE = 4'b0011; D_WDATA = 32'h12345678; #1;
    check_output("s_d_gnt", d_gnt_a, 1);
    check_output("s_i_gnt", i_gnt_a, 0);
    next_cycle();
    D_REQ = 1'b0; #1;
    check_output("s_acc_csn", csn_a, 0);
    check_output("s_acc_wen", wen_a, 0);
    check_output("s_acc_be", be_a, 32'h3);
    check_output("s_acc_addr", addr_a, 32'h020);
    check_output("s_acc_wdata", wdata_a, 32'h12345678);
    next_cycle();
    check_output("s_resp_rvalid", d_rvalid_a, 1);
    check_output("s_resp_rdata", d_rdata_a, 0);
    check_output("s_num_d", num_d_a, 1);
    check_output("s_resp_wen", wen_a, 1);
    check_output("s_hold_be", be_a, 32'h3);
    next_cycle();

    // starvation: both requesting, D stores win four windows, then I wins
    I_REQ = 1'b1; I_ADDR = 12'h040;
    D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 12'h024; D_BE = 4'hF; D_WDATA = 32'h0BADF00D; #1;
    for (int w = 0; w < 4; w++) begin
      check_output($sformatf("st_d_gnt%0d", w), d_gnt_a, 1);
      check_output($sformatf("st_i_gnt%0d", w), i_gnt_a, 0);
      next_cycle();
      next_cycle();
    end
    check_output("st5_i_gnt", i_gnt_a, 1);
    check_output("st5_d_gnt", d_gnt_a, 0);
    check_output("st5_d_rvalid", d_rvalid_a, 1);
    next_cycle();
    check_output("st_f_csn", csn_a, 0);
    check_output("st_f_addr", addr_a, 32'h040);
    next_cycle();
    next_cycle();
    check_output("st_f_rvalid", i_rvalid_a, 1);
    check_output("st_clr_d_gnt", d_gnt_a, 1);
    check_output("st_clr_i_gnt", i_gnt_a, 0);
    next_cycle();
    I_REQ = 1'b0; D_REQ = 1'b0; #1;
    check_output("st_num_d", num_d_a, 6);
    check_output("st_num_i", num_i_a, 2);
    next_cycle();
    check_output("st_last_rvalid", d_rvalid_a, 1);
    next_cycle();

    // back-to-back stores
    D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 12'h050; D_BE = 4'hF; D_WDATA = 32'hAAAA5555; #1;
    check_output("bb_gnt1", d_gnt_a, 1);
    next_cycle();
    check_output("bb_acc1_csn", csn_a, 0);
    check_output("bb_acc1_addr", addr_a, 32'h050);
    next_cycle();
    D_ADDR = 12'h054; #1;
    check_output("bb_resp1_rvalid", d_rvalid_a, 1);
    check_output("bb_gnt2", d_gnt_a, 1);
    next_cycle();
    D_REQ = 1'b0; #1;
    check_output("bb_acc2_csn", csn_a, 0);
    check_output("bb_acc2_addr", addr_a, 32'h054);
    next_cycle();
    check_output("bb_resp2_rvalid", d_rvalid_a, 1);
    next_cycle();
    check_output("bb_idle_csn", csn_a, 1);
    check_output("bb_idle_rvalid", d_rvalid_a, 0);

    // reset during WAIT of a fetch, then during ACCESS
    I_REQ = 1'b1; I_ADDR = 12'h060; #1;
    check_output("r_i_gnt", i_gnt_a, 1);
    next_cycle();
    I_REQ = 1'b0;
    next_cycle();
    RSTn = 1'b0; I_REQ = 1'b1; I_ADDR = 12'h070; #1;
    check_output("r_forced_gnt", i_gnt_a, 0);
    check_output("r_wait_csn", csn_a, 1);
    next_cycle();
    RSTn = 1'b1; #1;
    check_output("r_no_rvalid", i_rvalid_a, 0);
    check_output("r_no_d_rvalid", d_rvalid_a, 0);
    check_output("r_addr_cleared", addr_a, 0);
    check_output("r_regrant", i_gnt_a, 1);
    next_cycle();
    I_REQ = 1'b0; RSTn = 1'b0; #1;
    check_output("r_acc_csn_gated", csn_a, 1);
    check_output("r_num_i_pre", num_i_a, 1);
    next_cycle();
    RSTn = 1'b1; #1;
    check_output("r2_no_rvalid", i_rvalid_a, 0);
    check_output("r2_csn", csn_a, 1);
    check_output("r2_num_i", num_i_a, 0);

    // LAT=3 load on dut_b (dut_a runs the same load with LAT=1)
    D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 12'h030; #1;
    check_output("l3_gnt", d_gnt_b, 1);
    next_cycle();
    D_REQ = 1'b0; #1;
    check_output("l3_acc_csn", csn_b, 0);
    check_output("l3_acc_wen", wen_b, 1);
    next_cycle();
    MEM_RDATA = 32'h11111111; #1;
    check_output("l3_w1_rvalid", d_rvalid_b, 0);
    next_cycle();
    MEM_RDATA = 32'h22222222; #1;
    check_output("l1_rvalid", d_rvalid_a, 1);
    check_output("l1_rdata", d_rdata_a, 32'h11111111);
    check_output("l3_w2_rvalid", d_rvalid_b, 0);
    next_cycle();
    MEM_RDATA = 32'hCAFEF00D; #1;
    check_output("l3_w3_rvalid", d_rvalid_b, 0);
    next_cycle();
    MEM_RDATA = 32'h33333333; #1;
    check_output("l3_rvalid", d_rvalid_b, 1);
    check_output("l3_rdata", d_rdata_b, 32'hCAFEF00D);
    next_cycle();
    check_output("l3_post_rvalid", d_rvalid_b, 0);
    check_output("l3_hold_rdata", d_rdata_b, 32'hCAFEF00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between the instruction-fetch requester (I) and the data requester (D) of the multi-cycle core, and later a DMA on the D port.
- Accepts one request at a time, drives the memory's active-low chip-select/write-enable, waits out the memory read latency and returns a one-cycle response to the winning requester.
- D has priority; a starvation counter guarantees I progress.

Parameters:
- AW, 12, address width in words.
- DW, 32, data width; the byte-enable width is DW/8.
- LAT, 1, memory read latency in cycles after the access cycle. Legal range is 1..7.
- MAX_STARVE, 4, number of consecutive lost arbitrations after which I wins the next contested arbitration.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RSTn  in  1  synchronous, active-low reset.
- I_REQ  in  1  fetch request; held until I_GNT.
- I_ADDR  in  AW  fetch address.
- I_GNT  out  1  fetch request accepted this cycle (combinational).
- I_RVALID  out  1  one-cycle fetch data valid.
- I_RDATA  out  DW  fetch data.
- D_REQ  in  1  data request; held with its fields until D_GNT.
- D_WE  in  1  1 = store, 0 = load.
- D_ADDR  in  AW  data address.
- D_BE  in  DW/8  store byte enables.
- D_WDATA  in  DW  store data.
- D_GNT  out  1  data request accepted this cycle (combinational).
- D_RVALID  out  1  one-cycle load data / store acknowledge.
- D_RDATA  out  DW  load data.
- MEM_CSN  out  1  memory chip select, active low.
- MEM_WEN  out  1  memory write enable, active low.
- MEM_ADDR  out  AW  memory address.
- MEM_BE  out  DW/8  memory byte enables.
- MEM_WDATA  out  DW  memory write data.
- MEM_RDATA  in  DW  memory read data, valid LAT cycles after the access cycle.
- NUM_I_GNT  out  32  count of I grants since reset.
- NUM_D_GNT  out  32  count of D grants since reset.

Behaviour:
- Reset values (RSTn low at posedge):
  - state = IDLE.
  - I_GNT = D_GNT = 0, I_RVALID = D_RVALID = 0.
  - I_RDATA = D_RDATA = 0.
  - MEM_CSN = 1, MEM_WEN = 1, MEM_ADDR = 0, MEM_BE = 0, MEM_WDATA = 0.
  - Starvation counter = 0, NUM_* = 0.
  - GNT is forced 0 while RSTn is low.
- States:
  - IDLE: grant window.
  - ACCESS: exactly one cycle. MEM_CSN = 0; MEM_WEN = ~latched WE; address, BE and data come from the latched request. A fetch drives MEM_BE = all ones and MEM_WEN = 1.
  - WAIT: loads only; lasts exactly LAT cycles. MEM_RDATA is captured into the owner's RDATA register at the end of the last WAIT cycle.
  - RESP: one cycle. The owner's RVALID = 1. RESP is also a grant window.
- Transitions:
  - IDLE/RESP to ACCESS on any grant; otherwise to IDLE.
  - ACCESS to WAIT for a load or fetch; ACCESS to RESP for a store.
  - WAIT to RESP when the latency counter reaches LAT.
- Grant rule, evaluated in IDLE/RESP:
  - Only D requesting: D wins. Only I requesting: I wins.
  - Both requesting: D wins unless the starvation counter equals MAX_STARVE, in which case I wins.
  - At most one GNT is asserted per cycle.
  - The request fields are latched at the posedge ending the grant cycle.
- Starvation counter:
  - Increments (saturating at MAX_STARVE) in each grant-window cycle where I_REQ = 1 and D is granted.
  - Clears when I is granted.
  - Holds otherwise.
- Latency, with grant in cycle t:
  - Store: ACCESS at t+1, D_RVALID at t+2. D_RDATA is unchanged.
  - Load or fetch: ACCESS at t+1, WAIT from t+2 to t+1+LAT, RVALID at t+2+LAT.
- Throughput: a grant issued in a RESP cycle puts ACCESS in the next cycle, so back-to-back stores run at one per 2 cycles.
- RDATA of each port holds its value until the next response to that port.
- NUM_I_GNT and NUM_D_GNT increment on each respective GNT and wrap at 2^32.
- REQ dropped before GNT: no grant is issued and no memory access occurs.
- Reset mid-transaction (any state):
  - Return to IDLE next cycle.
  - No RVALID for the in-flight request.
  - MEM_CSN = 1 from the reset cycle on.
- Outside ACCESS: MEM_CSN = 1 and MEM_WEN = 1. MEM_ADDR, MEM_BE and MEM_WDATA hold their last values.

Test Plan:
- Reset, then I_REQ = 1, I_ADDR = 0x010, LAT = 1: I_GNT in cycle 0, MEM_CSN = 0 with MEM_ADDR = 0x010 in cycle 1, MEM_RDATA = 0xDEADBEEF in cycle 2, I_RVALID = 1 and I_RDATA = 0xDEADBEEF in cycle 3, NUM_I_GNT = 1.
- D store to ADDR = 0x020, BE = 4'b0011, WDATA = 0x12345678: D_GNT in cycle 0; cycle 1 shows MEM_CSN = 0, MEM_WEN = 0, MEM_BE = 0011; D_RVALID in cycle 2.
- I_REQ and D_REQ both held high continuously with D stores, MAX_STARVE = 4: D wins the first 4 windows, I wins the 5th, and the counter reads 0 after the I grant.
- LAT = 3 load: D_RVALID exactly 5 cycles after D_GNT, D_RDATA equal to MEM_RDATA as presented in the third cycle after ACCESS.
- RSTn driven low during WAIT of a fetch: no I_RVALID, MEM_CSN = 1 and all RVALIDs = 0 after reset; a new I_REQ afterwards is granted in the first IDLE cycle with RSTn high.
- Two stores back-to-back on D: the second D_GNT coincides with the first D_RVALID (RESP), and the ACCESS cycles are 2 cycles apart.
